// File: rtl/mul_acc_pkg.sv
// rtl/mul_acc_pkg.sv - shared state encoding and saturation bounds for the product accumulator
package mul_acc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCUM  = 2'd1;
  localparam state_t OUTPUT = 2'd2;

  // Bound in the low w bits of the result; callers slice [w-1:0].
  function automatic logic [63:0] sat_bound(input int w, input logic is_signed,
                                            input logic negative);
    if (!is_signed)
      return (64'd1 << w) - 64'd1;
    else if (negative)
      return 64'd1 << (w - 1);
    else
      return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/mul_acc_add_ovf.sv
// rtl/mul_acc_add_ovf.sv - accumulator adder with overflow detect; MUL_ACC_SATURATE_EN clamps on overflow
module mul_acc_add_ovf
  import mul_acc_pkg::*;
#(
  parameter int acc_w = 20
) (
  input  logic [acc_w-1:0] acc,
  input  logic [acc_w-1:0] addend,
  input  logic             mode,
  output logic [acc_w-1:0] sum,
  output logic             ovf
);

  logic [acc_w:0]   full;
  logic [acc_w-1:0] wrapped;
  logic             signed_ovf;

  assign full       = {1'b0, acc} + {1'b0, addend};
  assign wrapped    = full[acc_w-1:0];
  assign signed_ovf = (acc[acc_w-1] == addend[acc_w-1]) && (wrapped[acc_w-1] != acc[acc_w-1]);
  assign ovf        = mode ? signed_ovf : full[acc_w];

`ifdef MUL_ACC_SATURATE_EN
  logic [63:0] bound;

  // Signed overflow direction follows the shared operand sign.
  assign bound = sat_bound(acc_w, mode, acc[acc_w-1]);
  assign sum   = ovf ? bound[acc_w-1:0] : wrapped;
`else
  assign sum = wrapped;
`endif

endmodule

// File: rtl/mul_product_accumulator.sv
// rtl/mul_product_accumulator.sv - sums product packets into a wide accumulator; MUL_ACC_SATURATE_EN selects saturation
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int n     = 8,
  parameter int acc_w = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [2*n-1:0]   prod,
  input  logic             prod_signed,
  input  logic             prod_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [acc_w-1:0] acc,
  output logic             acc_overflow
);

  generate
    if (acc_w < 2*n || acc_w > 64) begin : g_bad_width
      $error("mul_product_accumulator: acc_w must be >= 2*n and <= 64");
    end
  endgenerate

  state_t           state;
  logic [acc_w-1:0] acc_q;
  logic             ovf_q;
  logic             mode_q;
  logic             eff_mode;
  logic [acc_w-1:0] ext;
  logic [acc_w-1:0] sum;
  logic             add_ovf;
  logic             beat;

  assign prod_ready   = (state == IDLE) || (state == ACCUM);
  assign acc_valid    = (state == OUTPUT);
  assign acc          = acc_q;
  assign acc_overflow = ovf_q;
  assign beat         = prod_valid && prod_ready;

  // Signedness is taken from the first beat only, then held for the packet.
  assign eff_mode = (state == IDLE) ? prod_signed : mode_q;
  assign ext      = eff_mode ? acc_w'($signed(prod)) : acc_w'(prod);

  mul_acc_add_ovf #(.acc_w(acc_w)) u_add (
    .acc    (acc_q),
    .addend (ext),
    .mode   (mode_q),
    .sum    (sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            mode_q <= prod_signed;
            acc_q  <= ext;
            ovf_q  <= 1'b0;
            state  <= prod_last ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= sum;
            ovf_q <= ovf_q | add_ovf;
            if (prod_last) state <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (acc_ready) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
- Sits directly downstream of the signed/unsigned multiplier.
- Consumes a stream of 2N-bit products and sums one packet of products, delimited by `prod_last`, into a wide accumulator.
- Presents the packet sum and a sticky overflow flag on a valid/ready output.
- Used for dot-product style homework pipelines.

Parameters:
- n, 8: multiplier operand width; products are 2*n bits.
- acc_w, 20: accumulator/result width; must be >= 2*n (elaboration-time assertion).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- prod_valid  input  1  product beat valid.
- prod_ready  output  1  block can accept a beat.
- prod  input  2*n  product value (two's complement if signed).
- prod_signed  input  1  signedness of packet, sampled on first beat only.
- prod_last  input  1  beat is last of packet.
- acc_valid  output  1  result valid.
- acc_ready  input  1  downstream accepts result.
- acc  output  acc_w  packet sum.
- acc_overflow  output  1  sticky: packet sum left the representable range.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - state=IDLE, acc=0, acc_overflow=0, acc_valid=0.
  - prod_ready=1 from the first cycle after reset.
  - Reset mid-packet or while holding a result discards everything; no partial result is ever emitted.
- Beat transfer: occurs on valid&&ready. Result transfer: occurs on acc_valid&&acc_ready.
- State machine:
  - IDLE: prod_ready=1. On first beat: latch mode=prod_signed; acc <= ext(prod); overflow <= 0.
    - prod_last=1 on that beat -> OUTPUT.
    - prod_last=0 -> ACCUM.
  - ACCUM: prod_ready=1. Each beat: acc <= acc + ext(prod); overflow |= ovf.
    - prod_last=1 -> OUTPUT.
  - OUTPUT: prod_ready=0; acc_valid=1; acc and acc_overflow held stable while acc_ready=0.
    - On transfer: acc <= 0, overflow <= 0 -> IDLE.
    - No beat is accepted in the same cycle as the result transfer; upstream sees ready one cycle later.
- Extension: ext() sign-extends prod to acc_w if mode=signed, else zero-extends. prod_signed on non-first beats is ignored.
- Overflow detection:
  - Unsigned: carry out of bit acc_w-1.
  - Signed: both addends share a sign and the sum sign differs.
- Latency: result visible (acc_valid=1) the cycle after the last beat is accepted.
- Without saturation: the sum wraps modulo 2^acc_w; the overflow flag still sets.
- Idle stalls (prod_valid=0 mid-packet): state and acc are held indefinitely.

Optional Feature:
- Macro: MUL_ACC_SATURATE_EN.
- Defined: on an overflowing add, acc clamps to the bound for the overflow direction and stays clamped for subsequent same-direction overflows. Later in-range adds continue from the clamped value. acc_overflow still sets.
  - Unsigned: 2^acc_w-1.
  - Signed positive: 2^(acc_w-1)-1.
  - Signed negative: -2^(acc_w-1).
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Package mul_acc_pkg:
  - state enum (IDLE, ACCUM, OUTPUT).
  - function computing saturation bounds for (acc_w, signed).
- Sub-module: mul_acc_add_ovf, a combinational block.
  - Inputs: acc, extended product, mode.
  - Outputs: sum (wrapped or saturated per macro) and ovf.
  - Instantiated once, so the FSM stays separate from the arithmetic.

Test Plan (n=8, acc_w=20):
- Unsigned: 3 beats 0xFE01, last on 3rd, acc_ready=1 -> acc=0x2FA03, overflow=0, acc_valid exactly one cycle after 3rd beat.
- Signed mixed: beats 0xFFF6 (-10), 0x0019 (25), first with prod_signed=1 -> acc=0x0000F, overflow=0.
- Overflow, 17 unsigned beats of 0xFE01:
  - Default -> acc=0x0DE11, overflow=1.
  - With MUL_ACC_SATURATE_EN -> acc=0xFFFFF, overflow=1.
- Overflow, 32 signed beats of 0x4000:
  - Default -> acc=0x80000, overflow=1.
  - With MUL_ACC_SATURATE_EN -> acc=0x7FFFF, overflow=1.
- Single-beat packet 0x0005 with last, acc_ready=0 for 5 cycles:
  - acc_valid and acc=0x00005 stable throughout; prod_ready=0 throughout.
  - After the transfer cycle, prod_ready=1 and the next packet starts from 0.
- rst asserted mid-packet after 2 beats:
  - Next cycle acc_valid=0, prod_ready=1.
  - New 1-beat packet 0x0003 -> acc=0x00003, overflow=0.
